// File: rtl/mr_wb_arb.sv
// Writeback arbiter: two producer FIFOs (ALU, LSU) merged onto decode's single
// register-file write port, round-robin with program-order override on same-register heads.

module mr_wb_arb_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          ready_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
    else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: cnt_q gates every read.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // Ready looks only at the registered count, never at a same-cycle pop.
  assign ready_o = !rst && (cnt_q < CW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (cnt_q <= CW'(DEPTH)) else $error("mr_wb_arb_fifo: count overflow");
      assert (!(pop_i && cnt_q == '0)) else $error("mr_wb_arb_fifo: pop from empty");
    end
  end
`endif
endmodule

module mr_wb_arb #(
  parameter int XLEN        = 32,
  parameter int REGSEL_BITS = 5,
  parameter int INSTID_BITS = 4,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_wb_valid,
  output logic                   alu_wb_ready,
  input  logic [INSTID_BITS-1:0] alu_wb_inst_id,
  input  logic [REGSEL_BITS-1:0] alu_wb_reg,
  input  logic [XLEN-1:0]        alu_wb_val,
  input  logic                   lsu_wb_valid,
  output logic                   lsu_wb_ready,
  input  logic [INSTID_BITS-1:0] lsu_wb_inst_id,
  input  logic [REGSEL_BITS-1:0] lsu_wb_reg,
  input  logic [XLEN-1:0]        lsu_wb_val,
  output logic                   wb_valid,
  output logic [REGSEL_BITS-1:0] wb_reg,
  output logic [XLEN-1:0]        wb_val,
  output logic [INSTID_BITS-1:0] wb_inst_id
);
  localparam int NSRC = 2;
  localparam int ALU  = 0;
  localparam int LSU  = 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [INSTID_BITS-1:0] id;
    logic [REGSEL_BITS-1:0] rd;
    logic [XLEN-1:0]        val;
  } wb_ent_t;
  localparam int EW = $bits(wb_ent_t);

  wb_ent_t [NSRC-1:0]         in_ent, head;
  logic    [NSRC-1:0]         in_vld, rdy, push, pop, ne;
  logic    [NSRC-1:0][CW-1:0] cnt;

  assign in_ent[ALU] = {alu_wb_inst_id, alu_wb_reg, alu_wb_val};
  assign in_ent[LSU] = {lsu_wb_inst_id, lsu_wb_reg, lsu_wb_val};
  assign in_vld      = {lsu_wb_valid, alu_wb_valid};
  assign alu_wb_ready = rdy[ALU];
  assign lsu_wb_ready = rdy[LSU];

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    // x0 writes complete the handshake but are never buffered.
    assign push[s] = in_vld[s] && rdy[s] && (in_ent[s].rd != '0);
    assign ne[s]   = (cnt[s] != '0);
    mr_wb_arb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[s]),
      .pop_i   (pop[s]),
      .din_i   (in_ent[s]),
      .head_o  (head[s]),
      .count_o (cnt[s]),
      .ready_o (rdy[s])
    );
  end

  logic                   last_lsu_q, last_lsu_d;
  logic                   wb_valid_q, wb_valid_d;
  wb_ent_t                wb_q, wb_d;
  logic                   gnt_any, gnt_lsu, same_rd;
  logic [INSTID_BITS-1:0] age;
  wb_ent_t                gnt_ent;

  // Same destination: older id wins (age MSB set => ALU older), so the later write lands last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_lsu = 1'b0;
    same_rd = (head[ALU].rd == head[LSU].rd);
    age     = head[ALU].id - head[LSU].id;
    if (ne[ALU] && ne[LSU]) begin
      gnt_any = 1'b1;
      if (same_rd) gnt_lsu = !age[INSTID_BITS-1] && (age != '0);
      else         gnt_lsu = !last_lsu_q;
    end else if (ne[ALU]) begin
      gnt_any = 1'b1;
    end else if (ne[LSU]) begin
      gnt_any = 1'b1;
      gnt_lsu = 1'b1;
    end
  end

  assign pop[ALU] = !rst && gnt_any && !gnt_lsu;
  assign pop[LSU] = !rst && gnt_any && gnt_lsu;
  assign gnt_ent  = gnt_lsu ? head[LSU] : head[ALU];

  always_comb begin
    wb_valid_d = gnt_any;
    wb_d       = wb_q;
    last_lsu_d = last_lsu_q;
    if (gnt_any) begin
      wb_d       = gnt_ent;
      last_lsu_d = gnt_lsu;
    end
  end

  // last_lsu resets to 1 so the ALU wins the first round-robin tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
      last_lsu_q <= 1'b1;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
      last_lsu_q <= last_lsu_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_reg     = wb_q.rd;
  assign wb_val     = wb_q.val;
  assign wb_inst_id = wb_q.id;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && ne[ALU] && ne[LSU] && same_rd)
      assert (head[ALU].id != head[LSU].id) else $error("mr_wb_arb: equal inst_id on same-register heads");
  end
`endif
endmodule

// File: tb/tb_mr_wb_arb.sv
// Directed bench for mr_wb_arb: expected writes are queued as stimulus is issued,
// a negedge monitor pops and compares every wb_valid beat.

module tb_mr_wb_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_wb_valid = 1'b0, lsu_wb_valid = 1'b0;
  logic        alu_wb_ready, lsu_wb_ready;
  logic [3:0]  alu_wb_inst_id = '0, lsu_wb_inst_id = '0;
  logic [4:0]  alu_wb_reg = '0, lsu_wb_reg = '0;
  logic [31:0] alu_wb_val = '0, lsu_wb_val = '0;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_val;
  logic [3:0]  wb_inst_id;

  always #5 clk = ~clk;

  mr_wb_arb #(.XLEN(32), .REGSEL_BITS(5), .INSTID_BITS(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready), .alu_wb_inst_id(alu_wb_inst_id),
    .alu_wb_reg(alu_wb_reg), .alu_wb_val(alu_wb_val),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready), .lsu_wb_inst_id(lsu_wb_inst_id),
    .lsu_wb_reg(lsu_wb_reg), .lsu_wb_val(lsu_wb_val),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_val(wb_val), .wb_inst_id(wb_inst_id)
  );

  typedef struct packed { logic [4:0] r; logic [31:0] v; logic [3:0] id; } exp_t;
  exp_t exp_q[$];
  int   n_vec = 0, n_bad = 0;
  logic alu_stall = 1'b0, lsu_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_wb(input logic [4:0] r, input logic [31:0] v, input logic [3:0] id);
    exp_q.push_back({r, v, id});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL wb_unexpected: got reg=%0d val=%h id=%0d, required no write", wb_reg, wb_val, wb_inst_id);
        end else begin
          e = exp_q.pop_front();
          if ({wb_reg, wb_val, wb_inst_id} !== e) begin
            n_bad++;
            $display("FAIL wb_order: got reg=%0d val=%h id=%0d, required reg=%0d val=%h id=%0d",
                     wb_reg, wb_val, wb_inst_id, e.r, e.v, e.id);
          end
        end
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the edge that took the transfer.
  task automatic alu_push(input logic [3:0] id, input logic [4:0] r, input logic [31:0] v);
    int k = 0;
    alu_wb_valid = 1'b1; alu_wb_inst_id = id; alu_wb_reg = r; alu_wb_val = v;
    @(negedge clk);
    while (!alu_wb_ready && k < 50) begin alu_stall = 1'b1; k++; @(negedge clk); end
    if (k == 50) check("alu_ready_timeout", 64'(alu_wb_ready), 64'd1);
    @(posedge clk); #1;
    alu_wb_valid = 1'b0;
  endtask

  task automatic lsu_push(input logic [3:0] id, input logic [4:0] r, input logic [31:0] v);
    int k = 0;
    lsu_wb_valid = 1'b1; lsu_wb_inst_id = id; lsu_wb_reg = r; lsu_wb_val = v;
    @(negedge clk);
    while (!lsu_wb_ready && k < 50) begin lsu_stall = 1'b1; k++; @(negedge clk); end
    if (k == 50) check("lsu_ready_timeout", 64'(lsu_wb_ready), 64'd1);
    @(posedge clk); #1;
    lsu_wb_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin @(negedge clk); k++; end
    check("drain_all_emitted", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_reg",   64'(wb_reg),   64'd0);
    check("rst_wb_val",   64'(wb_val),   64'd0);
    check("rst_wb_id",    64'(wb_inst_id), 64'd0);
    check("rst_alu_ready", 64'(alu_wb_ready), 64'd0);
    check("rst_lsu_ready", 64'(lsu_wb_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    do_reset();

    // single ALU write, 2-cycle latency
    expect_wb(5'd5, 32'hDEADBEEF, 4'd3);
    alu_push(4'd3, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_valid_cycle1", 64'(wb_valid), 64'd0);
    check("t1_lsu_ready", 64'(lsu_wb_ready), 64'd1);
    @(negedge clk);
    check("t1_valid_cycle2", 64'(wb_valid), 64'd1);
    check("t1_lsu_ready2", 64'(lsu_wb_ready), 64'd1);
    drain();

    // round-robin streams on distinct registers, ALU first after reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      expect_wb(5'(i + 1), 32'h100 + 32'(i), 4'(i));
      expect_wb(5'(i + 9), 32'h200 + 32'(i), 4'(i + 8));
    end
    alu_stall = 1'b0; lsu_stall = 1'b0;
    fork
      begin for (int i = 0; i < 8; i++) alu_push(4'(i), 5'(i + 1), 32'h100 + 32'(i)); end
      begin for (int j = 0; j < 8; j++) lsu_push(4'(j + 8), 5'(j + 9), 32'h200 + 32'(j)); end
    join
    check("t2_alu_backpressure", 64'(alu_stall), 64'd1);
    check("t2_lsu_backpressure", 64'(lsu_stall), 64'd1);
    drain();

    // same-register heads: older id first, regardless of round-robin state
    expect_wb(5'd7, 32'h11, 4'd2);
    expect_wb(5'd7, 32'h22, 4'd4);
    fork alu_push(4'd4, 5'd7, 32'h22); lsu_push(4'd2, 5'd7, 32'h11); join
    drain();
    expect_wb(5'd7, 32'h33, 4'd15);
    expect_wb(5'd7, 32'h44, 4'd1);
    fork alu_push(4'd1, 5'd7, 32'h44); lsu_push(4'd15, 5'd7, 32'h33); join
    drain();
    expect_wb(5'd3, 32'h55, 4'd5);
    expect_wb(5'd3, 32'h66, 4'd9);
    fork alu_push(4'd5, 5'd3, 32'h55); lsu_push(4'd9, 5'd3, 32'h66); join
    drain();

    // x0 writes handshake but are dropped
    alu_push(4'd1, 5'd0, 32'hBAD0);
    alu_push(4'd2, 5'd0, 32'hBAD1);
    alu_push(4'd3, 5'd0, 32'hBAD2);
    @(negedge clk);
    check("t4_no_wb_a", 64'(wb_valid), 64'd0);
    check("t4_alu_ready", 64'(alu_wb_ready), 64'd1);
    @(negedge clk);
    check("t4_no_wb_b", 64'(wb_valid), 64'd0);
    drain();

    // mid-operation reset flushes buffered entries
    do_reset();
    expect_wb(5'd1, 32'h501, 4'd1);
    fork
      begin alu_push(4'd1, 5'd1, 32'h501); alu_push(4'd2, 5'd2, 32'h502); end
      begin lsu_push(4'd9, 5'd9, 32'h509); lsu_push(4'd10, 5'd10, 32'h50A); end
    join
    rst = 1'b1;
    @(negedge clk);
    check("t5_alu_ready_in_rst", 64'(alu_wb_ready), 64'd0);
    check("t5_lsu_ready_in_rst", 64'(lsu_wb_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_wb_valid_after_rst", 64'(wb_valid), 64'd0);
    check("t5_alu_ready_after", 64'(alu_wb_ready), 64'd1);
    check("t5_lsu_ready_after", 64'(lsu_wb_ready), 64'd1);
    @(posedge clk); #1;
    drain();

    // full ALU FIFO: a pop does not open ready in the same cycle
    expect_wb(5'd1, 32'h600, 4'd0);
    expect_wb(5'd9, 32'h608, 4'd8);
    expect_wb(5'd2, 32'h601, 4'd1);
    expect_wb(5'd10, 32'h609, 4'd9);
    expect_wb(5'd3, 32'h602, 4'd2);
    expect_wb(5'd4, 32'h603, 4'd3);
    alu_stall = 1'b0; lsu_stall = 1'b0;
    fork
      begin for (int i = 0; i < 4; i++) alu_push(4'(i), 5'(i + 1), 32'h600 + 32'(i)); end
      begin lsu_push(4'd8, 5'd9, 32'h608); lsu_push(4'd9, 5'd10, 32'h609); end
    join
    check("t6_alu_stalled_when_full", 64'(alu_stall), 64'd1);
    check("t6_lsu_never_stalled", 64'(lsu_stall), 64'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
